jesd204_up_link_sequencer: RTL and testbench



---
 rtl/jesd204_up_link_sequencer_pkg.sv | 13 +
 rtl/jesd204_up_seq_timer.sv | 18 +
 rtl/jesd204_up_link_sequencer.sv | 157 +++++++++++++++
 tb/tb_jesd204_up_link_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jesd204_up_link_sequencer_pkg.sv
// jesd204_up_link_sequencer_pkg: register addresses and sequencer state encoding
package jesd204_up_link_sequencer_pkg;
  localparam logic [11:0] REG_LINK_DISABLE  = 12'h030;
  localparam logic [11:0] REG_LINK_STATE    = 12'h031;
  localparam logic [11:0] REG_LANES_DISABLE = 12'h080;
  localparam logic [11:0] REG_LINK_CONF0    = 12'h084;
  localparam logic [11:0] REG_LINK_CONF1    = 12'h085;
  localparam logic [11:0] REG_LINK_CONF2    = 12'h087;
  typedef enum logic [3:0] {
    ST_IDLE, ST_WR_LANES, ST_WR_OCT, ST_WR_MODE, ST_WR_BPMF, ST_ENABLE,
    ST_POLL, ST_UP, ST_BACKOFF, ST_DISABLE, ST_FAIL
  } state_t;
endpackage

// File: rtl/jesd204_up_seq_timer.sv
// jesd204_up_seq_timer: loadable down-counter that flags when it reaches zero
module jesd204_up_seq_timer #(
  parameter int W = 4
) (
  input  logic         up_clk,
  input  logic         ext_resetn,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt;
  assign expired = cnt == '0;
  always_ff @(posedge up_clk or negedge ext_resetn)
    if (!ext_resetn) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && !expired) cnt <= cnt - 1'b1;
endmodule

// File: rtl/jesd204_up_link_sequencer.sv
// jesd204_up_link_sequencer: autonomous JESD204 link bring-up over the common register map
module jesd204_up_link_sequencer
  import jesd204_up_link_sequencer_pkg::*;
#(
  parameter int NUM_LANES            = 1,
  parameter int DATA_PATH_WIDTH_LOG2 = 2,
  parameter int TIMEOUT_CYCLES       = 65536,
  parameter int MAX_RETRIES          = 3,
  parameter int BACKOFF_CYCLES       = 256
) (
  input  logic                 up_clk,
  input  logic                 ext_resetn,
  input  logic                 start,
  input  logic                 stop,
  input  logic [NUM_LANES-1:0] cfg_lanes_disable,
  input  logic [7:0]           cfg_octets_per_frame,
  input  logic [9:0]           cfg_octets_per_multiframe,
  input  logic [7:0]           cfg_beats_per_multiframe,
  input  logic                 cfg_disable_scrambler,
  input  logic                 cfg_disable_char_replacement,
  output logic                 up_wreq,
  output logic [11:0]          up_waddr,
  output logic [31:0]          up_wdata,
  output logic [11:0]          up_raddr,
  input  logic [31:0]          up_rdata,
  output logic                 busy,
  output logic                 link_up,
  output logic                 error,
  output logic [3:0]           attempt
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int BW = $clog2(BACKOFF_CYCLES);
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BO_LOAD = BW'(BACKOFF_CYCLES - 1);
  localparam logic [3:0] MAX_R = 4'(MAX_RETRIES);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 2**24) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range");
  end
  if (MAX_RETRIES < 0 || MAX_RETRIES > 15) begin : g_bad_retries
    $error("MAX_RETRIES out of range");
  end
  if (BACKOFF_CYCLES < 2) begin : g_bad_backoff
    $error("BACKOFF_CYCLES out of range");
  end
  if (DATA_PATH_WIDTH_LOG2 < 0 || DATA_PATH_WIDTH_LOG2 > 9) begin : g_bad_dpw
    $error("DATA_PATH_WIDTH_LOG2 does not fit the octets-per-multiframe field");
  end

  state_t state, state_d;
  logic [NUM_LANES-1:0] lanes_q, lanes_d;
  logic [7:0] opf_q, opf_d, bpmf_q, bpmf_d;
  logic [9:0] opmf_q, opmf_d;
  logic scr_q, scr_d, cr_q, cr_d;
  logic accept, ready, retry_ok, to_exp, bo_exp, enter_bo, enter_poll;
  logic wreq_d;
  logic [11:0] waddr_d;
  logic [31:0] wdata_d;
  logic [3:0] attempt_d;
  logic rdata_unused;

  assign rdata_unused = ^up_rdata[31:2];
  assign up_raddr = REG_LINK_STATE;
  assign ready = up_rdata[1:0] == 2'b00;
  assign retry_ok = attempt <= MAX_R;
  assign accept = start && (state == ST_IDLE || (state == ST_FAIL && !stop));
  assign enter_bo = state_d == ST_BACKOFF && state != ST_BACKOFF;
  assign enter_poll = state_d == ST_POLL && state != ST_POLL;

  // New configuration is visible to the first write in the same cycle it is accepted
  assign lanes_d = accept ? cfg_lanes_disable : lanes_q;
  assign opf_d   = accept ? cfg_octets_per_frame : opf_q;
  assign opmf_d  = accept ? cfg_octets_per_multiframe : opmf_q;
  assign bpmf_d  = accept ? cfg_beats_per_multiframe : bpmf_q;
  assign scr_d   = accept ? cfg_disable_scrambler : scr_q;
  assign cr_d    = accept ? cfg_disable_char_replacement : cr_q;

  assign attempt_d = accept ? 4'd1 :
                     (state == ST_BACKOFF && state_d == ST_WR_LANES) ?
                     (attempt == 4'd15 ? attempt : attempt + 4'd1) : attempt;

  jesd204_up_seq_timer #(.W(TW)) u_timeout (
    .up_clk(up_clk), .ext_resetn(ext_resetn), .load(enter_poll),
    .en(state == ST_POLL), .load_val(TO_LOAD), .expired(to_exp)
  );

  jesd204_up_seq_timer #(.W(BW)) u_backoff (
    .up_clk(up_clk), .ext_resetn(ext_resetn), .load(enter_bo),
    .en(state == ST_BACKOFF), .load_val(BO_LOAD), .expired(bo_exp)
  );

  always_comb begin
    state_d = state;
    if (stop && state != ST_IDLE) state_d = ST_DISABLE;
    else case (state)
      ST_IDLE, ST_FAIL: state_d = start ? ST_WR_LANES : state;
      ST_WR_LANES:      state_d = ST_WR_OCT;
      ST_WR_OCT:        state_d = ST_WR_MODE;
      ST_WR_MODE:       state_d = ST_WR_BPMF;
      ST_WR_BPMF:       state_d = ST_ENABLE;
      ST_ENABLE:        state_d = ST_POLL;
      ST_POLL:          state_d = ready ? ST_UP : !to_exp ? ST_POLL : retry_ok ? ST_BACKOFF : ST_FAIL;
      ST_UP:            state_d = ready ? ST_UP : retry_ok ? ST_BACKOFF : ST_FAIL;
      ST_BACKOFF:       state_d = bo_exp ? ST_WR_LANES : ST_BACKOFF;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wreq_d = 1'b1;
    waddr_d = REG_LINK_DISABLE;
    wdata_d = 32'd1;
    case (state_d)
      ST_WR_LANES: {waddr_d, wdata_d} = {REG_LANES_DISABLE, 32'(lanes_d)};
      ST_WR_OCT:   {waddr_d, wdata_d} = {REG_LINK_CONF0, 8'h0, opf_d, 6'h0, opmf_d};
      ST_WR_MODE:  {waddr_d, wdata_d} = {REG_LINK_CONF1, 30'h0, cr_d, scr_d};
      ST_WR_BPMF:  {waddr_d, wdata_d} = {REG_LINK_CONF2, 24'h0, bpmf_d};
      ST_ENABLE:   wdata_d = 32'd0;
      ST_DISABLE:  wdata_d = 32'd1;
      ST_BACKOFF:  {wreq_d, waddr_d, wdata_d} = enter_bo ? {1'b1, REG_LINK_DISABLE, 32'd1} : '0;
      default:     {wreq_d, waddr_d, wdata_d} = '0;
    endcase
  end

  always_ff @(posedge up_clk or negedge ext_resetn)
    if (!ext_resetn) begin
      state    <= ST_IDLE;
      lanes_q  <= '0;
      opf_q    <= '0;
      opmf_q   <= '0;
      bpmf_q   <= '0;
      scr_q    <= 1'b0;
      cr_q     <= 1'b0;
      up_wreq  <= 1'b0;
      up_waddr <= '0;
      up_wdata <= '0;
      busy     <= 1'b0;
      link_up  <= 1'b0;
      error    <= 1'b0;
      attempt  <= '0;
    end else begin
      state    <= state_d;
      lanes_q  <= lanes_d;
      opf_q    <= opf_d;
      opmf_q   <= opmf_d;
      bpmf_q   <= bpmf_d;
      scr_q    <= scr_d;
      cr_q     <= cr_d;
      up_wreq  <= wreq_d;
      up_waddr <= waddr_d;
      up_wdata <= wdata_d;
      busy     <= !(state_d inside {ST_IDLE, ST_UP, ST_FAIL});
      link_up  <= state_d == ST_UP;
      error    <= state_d == ST_FAIL;
      attempt  <= attempt_d;
    end
endmodule

// File: tb/tb_jesd204_up_link_sequencer.sv
// tb_jesd204_up_link_sequencer: directed self-checking bench for the link sequencer
module tb_jesd204_up_link_sequencer;
  logic up_clk = 1'b0;
  logic ext_resetn = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic [1:0] cfg_lanes_disable = '0;
  logic [7:0] cfg_octets_per_frame = '0;
  logic [9:0] cfg_octets_per_multiframe = '0;
  logic [7:0] cfg_beats_per_multiframe = '0;
  logic cfg_disable_scrambler = 1'b0;
  logic cfg_disable_char_replacement = 1'b0;
  logic [31:0] up_rdata = 32'h3;
  logic up_wreq, busy, link_up, error;
  logic [11:0] up_waddr, up_raddr;
  logic [31:0] up_wdata;
  logic [3:0] attempt;
  int checks = 0;
  int failures = 0;

  always #5 up_clk = ~up_clk;

  jesd204_up_link_sequencer #(
    .NUM_LANES(2), .DATA_PATH_WIDTH_LOG2(2), .TIMEOUT_CYCLES(16),
    .MAX_RETRIES(1), .BACKOFF_CYCLES(4)
  ) dut (
    .up_clk(up_clk), .ext_resetn(ext_resetn), .start(start), .stop(stop),
    .cfg_lanes_disable(cfg_lanes_disable),
    .cfg_octets_per_frame(cfg_octets_per_frame),
    .cfg_octets_per_multiframe(cfg_octets_per_multiframe),
    .cfg_beats_per_multiframe(cfg_beats_per_multiframe),
    .cfg_disable_scrambler(cfg_disable_scrambler),
    .cfg_disable_char_replacement(cfg_disable_char_replacement),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata),
    .up_raddr(up_raddr), .up_rdata(up_rdata),
    .busy(busy), .link_up(link_up), .error(error), .attempt(attempt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge up_clk);
  endtask

  task automatic wr(input string tag, input logic [11:0] a, input logic [31:0] d);
    chk({tag, "_wreq"}, 32'(up_wreq), 32'd1);
    chk({tag, "_waddr"}, 32'(up_waddr), 32'(a));
    chk({tag, "_wdata"}, up_wdata, d);
  endtask

  task automatic idle_bus(input string tag);
    chk({tag, "_wreq"}, 32'(up_wreq), 32'd0);
  endtask

  task automatic go(input logic [1:0] l, input logic [7:0] opf, input logic [9:0] opmf,
                    input logic [7:0] bpmf, input logic scr, input logic cr);
    cfg_lanes_disable = l;
    cfg_octets_per_frame = opf;
    cfg_octets_per_multiframe = opmf;
    cfg_beats_per_multiframe = bpmf;
    cfg_disable_scrambler = scr;
    cfg_disable_char_replacement = cr;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int n;
    int starts;
    step(2);
    chk("rst_wreq", 32'(up_wreq), 32'd0);
    chk("rst_waddr", 32'(up_waddr), 32'd0);
    chk("rst_wdata", up_wdata, 32'd0);
    chk("rst_raddr", 32'(up_raddr), 32'h031);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_link_up", 32'(link_up), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_attempt", 32'(attempt), 32'd0);
    ext_resetn = 1'b1;
    step();
    idle_bus("idle");

    // nominal bring-up, ready 10 cycles after the enable write
    go(2'd0, 8'd4, 10'd31, 8'd8, 1'b0, 1'b0);
    wr("n_lanes", 12'h080, 32'h0);
    chk("n_busy", 32'(busy), 32'd1);
    chk("n_attempt", 32'(attempt), 32'd1);
    step(); wr("n_oct", 12'h084, 32'h0004_001F);
    step(); wr("n_mode", 12'h085, 32'h0);
    step(); wr("n_bpmf", 12'h087, 32'h8);
    step(); wr("n_en", 12'h030, 32'h0);
    for (int i = 1; i <= 9; i++) begin
      step();
      idle_bus("n_poll");
      chk("n_poll_link_up", 32'(link_up), 32'd0);
    end
    step();
    up_rdata = 32'h0;
    chk("n_c10_link_up", 32'(link_up), 32'd0);
    step();
    chk("n_link_up", 32'(link_up), 32'd1);
    chk("n_up_busy", 32'(busy), 32'd0);
    chk("n_up_attempt", 32'(attempt), 32'd1);
    chk("n_raddr", 32'(up_raddr), 32'h031);

    // link loss in UP
    up_rdata = 32'h2;
    step();
    up_rdata = 32'h3;
    wr("l_bo", 12'h030, 32'h1);
    chk("l_link_up", 32'(link_up), 32'd0);
    chk("l_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      idle_bus("l_wait");
    end
    step(); wr("l_lanes", 12'h080, 32'h0);
    chk("l_attempt", 32'(attempt), 32'd2);
    step(4); wr("l_en", 12'h030, 32'h0);
    up_rdata = 32'h0;
    step();
    chk("l_poll_link_up", 32'(link_up), 32'd0);
    step();
    chk("l_link_up_again", 32'(link_up), 32'd1);

    // stop from UP
    stop = 1'b1;
    step();
    stop = 1'b0;
    wr("s_dis", 12'h030, 32'h1);
    step();
    idle_bus("s_idle");
    chk("s_busy", 32'(busy), 32'd0);
    chk("s_link_up", 32'(link_up), 32'd0);
    chk("s_attempt_hold", 32'(attempt), 32'd2);

    // timeout on attempt 1, success on attempt 2; cfg inputs change after start
    up_rdata = 32'h3;
    go(2'd1, 8'd2, 10'd15, 8'd4, 1'b1, 1'b1);
    wr("t_lanes", 12'h080, 32'h1);
    chk("t_attempt", 32'(attempt), 32'd1);
    cfg_lanes_disable = 2'd2;
    cfg_octets_per_frame = 8'hFF;
    cfg_octets_per_multiframe = 10'h3FF;
    cfg_beats_per_multiframe = 8'hFF;
    cfg_disable_scrambler = 1'b0;
    cfg_disable_char_replacement = 1'b0;
    step(); wr("t_oct", 12'h084, 32'h0002_000F);
    step(); wr("t_mode", 12'h085, 32'h3);
    step(); wr("t_bpmf", 12'h087, 32'h4);
    step(); wr("t_en", 12'h030, 32'h0);
    for (int i = 1; i <= 16; i++) begin
      step();
      idle_bus("t_poll");
    end
    step(); wr("t_bo", 12'h030, 32'h1);
    chk("t_bo_attempt", 32'(attempt), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      idle_bus("t_wait");
      chk("t_wait_busy", 32'(busy), 32'd1);
    end
    step(); wr("t_re_lanes", 12'h080, 32'h1);
    chk("t_re_attempt", 32'(attempt), 32'd2);
    step(); wr("t_re_oct", 12'h084, 32'h0002_000F);
    step(); wr("t_re_mode", 12'h085, 32'h3);
    step(); wr("t_re_bpmf", 12'h087, 32'h4);
    step(); wr("t_re_en", 12'h030, 32'h0);
    up_rdata = 32'h0;
    step();
    chk("t_poll_link_up", 32'(link_up), 32'd0);
    step();
    chk("t_link_up", 32'(link_up), 32'd1);
    chk("t_up_attempt", 32'(attempt), 32'd2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();

    // retries exhausted: FAIL after two attempts
    up_rdata = 32'h3;
    go(2'd0, 8'd4, 10'd31, 8'd8, 1'b0, 1'b0);
    n = 0;
    starts = (up_wreq && up_waddr == 12'h080) ? 1 : 0;
    while (!error && n < 200) begin
      step();
      n++;
      if (up_wreq && up_waddr == 12'h080) starts++;
    end
    chk("x_cycles_to_fail", 32'(n), 32'd46);
    chk("x_starts", 32'(starts), 32'd2);
    chk("x_error", 32'(error), 32'd1);
    chk("x_busy", 32'(busy), 32'd0);
    chk("x_attempt", 32'(attempt), 32'd2);
    chk("x_link_up", 32'(link_up), 32'd0);
    step();
    chk("x_error_hold", 32'(error), 32'd1);
    idle_bus("x_idle");

    // restart from FAIL, then stop+start together in POLL
    go(2'd0, 8'd4, 10'd31, 8'd8, 1'b0, 1'b0);
    wr("r_lanes", 12'h080, 32'h0);
    chk("r_attempt", 32'(attempt), 32'd1);
    chk("r_error", 32'(error), 32'd0);
    step(5);
    idle_bus("r_poll");
    chk("r_poll_busy", 32'(busy), 32'd1);
    stop = 1'b1;
    start = 1'b1;
    step();
    stop = 1'b0;
    start = 1'b0;
    wr("ss_dis", 12'h030, 32'h1);
    step();
    idle_bus("ss_idle");
    chk("ss_busy", 32'(busy), 32'd0);
    step(2);
    idle_bus("ss_no_start");
    chk("ss_busy_hold", 32'(busy), 32'd0);
    chk("ss_attempt", 32'(attempt), 32'd1);

    // asynchronous reset during WR_OCT
    go(2'd0, 8'd4, 10'd31, 8'd8, 1'b0, 1'b0);
    step();
    wr("a_oct", 12'h084, 32'h0004_001F);
    #2 ext_resetn = 1'b0;
    #1;
    chk("a_wreq", 32'(up_wreq), 32'd0);
    chk("a_waddr", 32'(up_waddr), 32'd0);
    chk("a_wdata", up_wdata, 32'd0);
    chk("a_raddr", 32'(up_raddr), 32'h031);
    chk("a_busy", 32'(busy), 32'd0);
    chk("a_link_up", 32'(link_up), 32'd0);
    chk("a_error", 32'(error), 32'd0);
    chk("a_attempt", 32'(attempt), 32'd0);
    step(2);
    ext_resetn = 1'b1;
    step(2);
    idle_bus("a_after");
    chk("a_after_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
